uart_time_tx: RTL and testbench

Transmit-side companion to the command receiver in `uart_top`. On a single-cycle request, it snapshots the current watch/stopwatch time and serialises it on `tx` as an ASCII line "HH:MM:SS.CC" (optionally followed by CR LF). The link format is 8N1, LSB first, at the same baud rate as the receiver. It sits between the time-keeping datapath and the `tx` pin, giving the PC a readback path for values that the receiver's commands change.

---
 rtl/uart_time_tx_if.sv | 21 ++
 rtl/uart_time_tx.sv | 170 +++++++++++++++++
 tb/tb_uart_time_tx.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_time_tx_if.sv
// Time-readback transmitter bus: request + time fields in, serial line and status out.
interface uart_time_tx_if;
    logic       i_req;
    logic [4:0] i_hour;
    logic [5:0] i_min;
    logic [5:0] i_sec;
    logic [6:0] i_cc;
    logic       tx;
    logic       o_busy;
    logic       o_done;

    modport master (
        output i_req, i_hour, i_min, i_sec, i_cc,
        input  tx, o_busy, o_done
    );

    modport slave (
        input  i_req, i_hour, i_min, i_sec, i_cc,
        output tx, o_busy, o_done
    );
endinterface

// File: rtl/uart_time_tx.sv
// Serialises a latched "HH:MM:SS.CC" time snapshot as 8N1 UART, LSB first.
// Define UART_TIME_TX_CRLF_EN to append CR LF (13 bytes instead of 11).
module uart_time_tx #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic           clk,
    input  logic           rst,
    uart_time_tx_if.slave  bus
);
    localparam int unsigned DIV = CLK_FREQ / BAUD;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
`ifdef UART_TIME_TX_CRLF_EN
    localparam int unsigned NBYTES = 13;
`else
    localparam int unsigned NBYTES = 11;
`endif
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [3:0]    BYTE_LAST = 4'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [3:0]    byte_q, byte_d;
    logic [4:0]    hour_q, hour_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic [6:0]    cc_q, cc_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic [7:0]    cur_byte;
    logic          bit_end;

    // Values above 99 saturate so each field always yields exactly two digits.
    function automatic logic [7:0] digit(input logic [6:0] v, input logic tens);
        logic [6:0] s;
        s = (v > 7'd99) ? 7'd99 : v;
        if (tens)
            return 8'h30 + 8'(s / 7'd10);
        else
            return 8'h30 + 8'(s % 7'd10);
    endfunction

    always_comb begin
        case (byte_q)
            4'd0:    cur_byte = digit({2'b00, hour_q}, 1'b1);
            4'd1:    cur_byte = digit({2'b00, hour_q}, 1'b0);
            4'd2:    cur_byte = 8'h3A;
            4'd3:    cur_byte = digit({1'b0, min_q}, 1'b1);
            4'd4:    cur_byte = digit({1'b0, min_q}, 1'b0);
            4'd5:    cur_byte = 8'h3A;
            4'd6:    cur_byte = digit({1'b0, sec_q}, 1'b1);
            4'd7:    cur_byte = digit({1'b0, sec_q}, 1'b0);
            4'd8:    cur_byte = 8'h2E;
            4'd9:    cur_byte = digit(cc_q, 1'b1);
            4'd10:   cur_byte = digit(cc_q, 1'b0);
            4'd11:   cur_byte = 8'h0D;
            4'd12:   cur_byte = 8'h0A;
            default: cur_byte = 8'hFF;
        endcase
    end

    assign bit_end = (baud_q == BAUD_LAST);

    // tx_d is the level for the cycle after the edge, so the line comes straight off a flop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        cc_d    = cc_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (bus.i_req) begin
                    state_d = START;
                    baud_d  = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                    hour_d  = bus.i_hour;
                    min_d   = bus.i_min;
                    sec_d   = bus.i_sec;
                    cc_d    = bus.i_cc;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = cur_byte[0];
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (byte_q == BYTE_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                    end else begin
                        byte_d  = byte_q + 4'd1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            cc_q    <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            cc_q    <= cc_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx     = tx_q;
    assign bus.o_busy = (state_q != IDLE);
    assign bus.o_done = done_q;
endmodule

// File: tb/tb_uart_time_tx.sv
// Self-checking bench for uart_time_tx: randomized time fields decoded by a bench UART receiver.
module tb_uart_time_tx;
    localparam int unsigned CLK_FREQ = 80;
    localparam int unsigned BAUD     = 10;
    localparam int DIV = 8;
`ifdef UART_TIME_TX_CRLF_EN
    localparam int NB = 13;
`else
    localparam int NB = 11;
`endif
    localparam int FRAME  = 10 * DIV * NB;
    localparam int BUDGET = FRAME + 4 * DIV;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_time_tx_if bus();

    uart_time_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] rx_buf [16];
    logic [7:0] exp_buf [16];
    int rx_n, rx_err, done_at, done_n, busy_at;

    function automatic int sat99(input int v);
        return (v > 99) ? 99 : v;
    endfunction

    // Reference: the line is just the printf of the saturated fields, plus optional CR LF.
    function automatic void model(input int h, input int m, input int s, input int c);
        string str;
        str = $sformatf("%02d:%02d:%02d.%02d", sat99(h), sat99(m), sat99(s), sat99(c));
        for (int i = 0; i < 16; i++) exp_buf[i] = 8'h00;
        for (int i = 0; i < 11; i++) exp_buf[i] = str[i];
`ifdef UART_TIME_TX_CRLF_EN
        exp_buf[11] = 8'h0D;
        exp_buf[12] = 8'h0A;
`endif
    endfunction

    task automatic set_fields(input int h, input int m, input int s, input int c);
        bus.i_hour = 5'(h);
        bus.i_min  = 6'(m);
        bus.i_sec  = 6'(s);
        bus.i_cc   = 7'(c);
    endtask

    task automatic pulse_req();
        bus.i_req = 1'b1;
        @(negedge clk);
        bus.i_req = 1'b0;
    endtask

    // Mid-bit sampling receiver; starts on the first busy negedge of a frame.
    task automatic capture(input int budget);
        int phase;
        int cnt;
        logic [7:0] sh;
        phase = -1; cnt = 0; sh = '0;
        rx_n = 0; rx_err = 0; done_at = -1; done_n = 0; busy_at = -1;
        for (int c = 0; c < budget; c++) begin
            if (bus.o_busy === 1'b1 && busy_at < 0) busy_at = c;
            if (bus.o_done === 1'b1) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
            if (phase < 0) begin
                if (bus.tx === 1'b0) begin phase = 0; cnt = 0; end
            end else begin
                cnt++;
            end
            if (phase >= 0 && cnt == DIV / 2 + phase * DIV) begin
                if (phase == 0 && bus.tx !== 1'b0) rx_err++;
                if (phase >= 1 && phase <= 8) sh[phase-1] = bus.tx;
                if (phase == 9) begin
                    if (bus.tx !== 1'b1) rx_err++;
                    if (rx_n < 16) rx_buf[rx_n] = sh;
                    rx_n++;
                    phase = -1;
                end else begin
                    phase++;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus.i_req = 1'b0;
        set_fields(0, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.tx, bus.o_busy, bus.o_done} !== 3'b100) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d tx/busy/done got=%b want=100", i, {bus.tx, bus.o_busy, bus.o_done});
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.tx, bus.o_busy, bus.o_done} !== 3'b100) begin
                miscompares++;
                $display("FAIL reset_release cyc=%0d tx/busy/done got=%b want=100", i, {bus.tx, bus.o_busy, bus.o_done});
            end
        end
    endtask

    task automatic test_basic();
        set_fields(12, 34, 56, 78);
        model(12, 34, 56, 78);
        pulse_req();
        vectors++;
        if ({bus.o_busy, bus.tx} !== 2'b10) begin
            miscompares++;
            $display("FAIL basic_latency busy/tx got=%b want=10", {bus.o_busy, bus.tx});
        end
        capture(BUDGET);
        vectors++;
        if (rx_n !== NB || rx_err !== 0) begin
            miscompares++;
            $display("FAIL basic_count bytes=%0d framing_errs=%0d want bytes=%0d errs=0", rx_n, rx_err, NB);
        end
        for (int i = 0; i < NB && i < rx_n; i++) begin
            vectors++;
            if (rx_buf[i] !== exp_buf[i]) begin
                miscompares++;
                $display("FAIL basic_byte[%0d] got=%h want=%h", i, rx_buf[i], exp_buf[i]);
            end
        end
        vectors++;
        if (done_n !== 1 || done_at - busy_at !== FRAME) begin
            miscompares++;
            $display("FAIL basic_done pulses=%0d len=%0d want pulses=1 len=%0d", done_n, done_at - busy_at, FRAME);
        end
    endtask

    task automatic test_snapshot();
        set_fields(12, 34, 56, 78);
        model(12, 34, 56, 78);
        pulse_req();
        fork
            capture(BUDGET);
            begin
                repeat (5 * DIV) @(negedge clk);
                set_fields(23, 59, 59, 99);
                pulse_req();
                repeat (40 * DIV) @(negedge clk);
                pulse_req();
            end
        join
        vectors++;
        if (rx_n !== NB || rx_err !== 0 || done_n !== 1) begin
            miscompares++;
            $display("FAIL snap_count bytes=%0d errs=%0d dones=%0d want %0d/0/1", rx_n, rx_err, done_n, NB);
        end
        for (int i = 0; i < NB && i < rx_n; i++) begin
            vectors++;
            if (rx_buf[i] !== exp_buf[i]) begin
                miscompares++;
                $display("FAIL snap_byte[%0d] got=%h want=%h", i, rx_buf[i], exp_buf[i]);
            end
        end
    endtask

    task automatic test_limits();
        int tv [2][4];
        tv[0] = '{0, 0, 0, 120};
        tv[1] = '{31, 63, 60, 99};
        for (int t = 0; t < 2; t++) begin
            set_fields(tv[t][0], tv[t][1], tv[t][2], tv[t][3]);
            model(tv[t][0], tv[t][1], tv[t][2], tv[t][3]);
            pulse_req();
            capture(BUDGET);
            vectors++;
            if (rx_n !== NB || rx_err !== 0 || done_n !== 1) begin
                miscompares++;
                $display("FAIL limits%0d_count bytes=%0d errs=%0d dones=%0d want %0d/0/1", t, rx_n, rx_err, done_n, NB);
            end
            for (int i = 0; i < NB && i < rx_n; i++) begin
                vectors++;
                if (rx_buf[i] !== exp_buf[i]) begin
                    miscompares++;
                    $display("FAIL limits%0d_byte[%0d] got=%h want=%h", t, i, rx_buf[i], exp_buf[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        set_fields(1, 2, 3, 4);
        pulse_req();
        repeat (FRAME - 1) @(negedge clk);
        vectors++;
        if ({bus.o_busy, bus.o_done} !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b_last_stop busy/done got=%b want=10", {bus.o_busy, bus.o_done});
        end
        set_fields(9, 8, 7, 6);
        model(9, 8, 7, 6);
        pulse_req();
        vectors++;
        if ({bus.o_busy, bus.o_done, bus.tx} !== 3'b011) begin
            miscompares++;
            $display("FAIL b2b_req_ignored busy/done/tx got=%b want=011", {bus.o_busy, bus.o_done, bus.tx});
        end
        pulse_req();
        vectors++;
        if ({bus.o_busy, bus.o_done, bus.tx} !== 3'b100) begin
            miscompares++;
            $display("FAIL b2b_req_after_done busy/done/tx got=%b want=100", {bus.o_busy, bus.o_done, bus.tx});
        end
        capture(BUDGET);
        vectors++;
        if (rx_n !== NB || rx_err !== 0 || done_n !== 1 || done_at - busy_at !== FRAME) begin
            miscompares++;
            $display("FAIL b2b_frame bytes=%0d errs=%0d dones=%0d len=%0d want %0d/0/1/%0d",
                     rx_n, rx_err, done_n, done_at - busy_at, NB, FRAME);
        end
        for (int i = 0; i < NB && i < rx_n; i++) begin
            vectors++;
            if (rx_buf[i] !== exp_buf[i]) begin
                miscompares++;
                $display("FAIL b2b_byte[%0d] got=%h want=%h", i, rx_buf[i], exp_buf[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b3;
        int bad;
        set_fields(12, 34, 56, 78);
        model(12, 34, 56, 78);
        b3 = exp_buf[3];
        pulse_req();
        repeat (3 * 10 * DIV + 5 * DIV + DIV / 2) @(negedge clk);
        vectors++;
        if (bus.tx !== b3[4]) begin
            miscompares++;
            $display("FAIL midrst_bit4 tx got=%b want=%b", bus.tx, b3[4]);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({bus.tx, bus.o_busy, bus.o_done} !== 3'b100) begin
            miscompares++;
            $display("FAIL midrst_async tx/busy/done got=%b want=100", {bus.tx, bus.o_busy, bus.o_done});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (10 * DIV) begin
            @(negedge clk);
            if ({bus.tx, bus.o_busy, bus.o_done} !== 3'b100) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL midrst_quiet bad_cycles got=%0d want=0", bad);
        end
        set_fields(7, 45, 9, 3);
        model(7, 45, 9, 3);
        pulse_req();
        capture(BUDGET);
        vectors++;
        if (rx_n !== NB || rx_err !== 0 || done_n !== 1) begin
            miscompares++;
            $display("FAIL midrst_frame bytes=%0d errs=%0d dones=%0d want %0d/0/1", rx_n, rx_err, done_n, NB);
        end
        for (int i = 0; i < NB && i < rx_n; i++) begin
            vectors++;
            if (rx_buf[i] !== exp_buf[i]) begin
                miscompares++;
                $display("FAIL midrst_byte[%0d] got=%h want=%h", i, rx_buf[i], exp_buf[i]);
            end
        end
    endtask

    task automatic test_random();
        int h, m, s, c;
        for (int f = 0; f < 4; f++) begin
            h = int'($urandom_range(0, 31));
            m = int'($urandom_range(0, 63));
            s = int'($urandom_range(0, 63));
            c = int'($urandom_range(0, 127));
            set_fields(h, m, s, c);
            model(h, m, s, c);
            pulse_req();
            capture(BUDGET);
            vectors++;
            if (rx_n !== NB || rx_err !== 0 || done_n !== 1 || done_at - busy_at !== FRAME) begin
                miscompares++;
                $display("FAIL rand%0d_frame bytes=%0d errs=%0d dones=%0d len=%0d want %0d/0/1/%0d",
                         f, rx_n, rx_err, done_n, done_at - busy_at, NB, FRAME);
            end
            for (int i = 0; i < NB && i < rx_n; i++) begin
                vectors++;
                if (rx_buf[i] !== exp_buf[i]) begin
                    miscompares++;
                    $display("FAIL rand%0d_byte[%0d] in=%0d:%0d:%0d.%0d got=%h want=%h",
                             f, i, h, m, s, c, rx_buf[i], exp_buf[i]);
                end
            end
        end
    endtask

    initial begin
        bus.i_req = 1'b0;
        set_fields(0, 0, 0, 0);
        test_reset();
        test_basic();
        test_snapshot();
        test_limits();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
